sync_fifo_prog: RTL and testbench

Parametrised single-clock FIFO, the next generation of the team's synchronous FIFO. It adds programmable almost-full and almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode. It sits between a producer and a consumer in one clock domain and uses the same wr_en/rd_en/full/empty handshake already used on the FIFO interface.

---
 rtl/sync_fifo_prog.sv | 116 +++++++++++
 tb/tb_sync_fifo_prog.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// occupancy count, sticky overflow/underflow flags and optional FWFT read mode.
module sync_fifo_prog #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          wr_acc, rd_acc;

  // All status flags decode from the registered count, never from this cycle's requests.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A new error event in the same cycle as clr_err must not be lost.
    if (wr_en & full)       ovf_d = 1'b1;
    else if (clr_err)       ovf_d = 1'b0;
    if (rd_en & empty)      unf_d = 1'b1;
    else if (clr_err)       unf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= wr_data;
  end

  if (FWFT != 0) begin : g_fwft
    // Gate with empty so the output reads zero out of reset instead of stale storage.
    assign rd_data  = empty ? '0 : mem[rd_ptr_q];
    assign rd_valid = ~empty;
  end else begin : g_std
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= mem[rd_ptr_q];
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: one standard-read and one FWFT instance
// share the same stimulus; expected values are hand-derived constants.
module tb_sync_fifo_prog;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, rd_en, clr_err;
  logic [7:0] wr_data;

  logic [7:0] r0_data, r1_data;
  logic       r0_valid, r1_valid;
  logic       full0, empty0, af0, ae0, ovf0, unf0;
  logic       full1, empty1, af1, ae1, ovf1, unf1;
  logic [4:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_prog #(.WIDTH(8), .DEPTH(16), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(r0_data), .rd_valid(r0_valid), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(cnt0), .overflow(ovf0),
    .underflow(unf0), .clr_err(clr_err)
  );

  sync_fifo_prog #(.WIDTH(8), .DEPTH(16), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(r1_data), .rd_valid(r1_valid), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(cnt1), .overflow(ovf1),
    .underflow(unf1), .clr_err(clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = 8'h00;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_count", cnt0, 0);
    chk("rst_empty", empty0, 1);
    chk("rst_aempty", ae0, 1);
    chk("rst_full", full0, 0);
    chk("rst_afull", af0, 0);
    chk("rst_valid0", r0_valid, 0);
    chk("rst_data0", r0_data, 0);
    chk("rst_valid1", r1_valid, 0);
    chk("rst_data1", r1_data, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_unf", unf0, 0);

    // Fill with 0x00..0x0F, then one rejected write of 0xAA
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'(i);
      tick();
      chk("fill_count", cnt0, i + 1);
      chk("fill_afull", af0, (i + 1 >= 14) ? 1 : 0);
      chk("fill_aempty", ae0, (i + 1 <= 2) ? 1 : 0);
    end
    wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    chk("ovf_count", cnt0, 16);
    chk("ovf_full", full0, 1);
    chk("ovf_flag", ovf0, 1);
    chk("ovf_fwft_count", cnt1, 16);

    // Drain: both modes must return 0x00..0x0F in order
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_fwft_data", r1_data, i);
      chk("drain_fwft_valid", r1_valid, 1);
      tick();
      chk("drain_valid", r0_valid, 1);
      chk("drain_data", r0_data, i);
    end
    rd_en = 1'b0;
    tick();
    chk("drain_valid_off", r0_valid, 0);
    chk("drain_hold", r0_data, 8'h0F);
    chk("drain_empty", empty0, 1);
    chk("drain_ovf_sticky", ovf0, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_ovf", ovf0, 0);

    // Underflow and clear priority
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("unf_flag", unf0, 1);
    chk("unf_count", cnt0, 0);
    chk("unf_valid", r0_valid, 0);
    clr_err = 1'b1;
    tick();
    chk("unf_clr", unf0, 0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("unf_set_wins", unf0, 1);
    tick();
    clr_err = 1'b0;
    chk("unf_clr2", unf0, 0);

    // Simultaneous read/write while full
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'(8'h40 + i);
      tick();
    end
    chk("full2_count", cnt0, 16);
    wr_data = 8'hBB;
    rd_en = 1'b1;
    tick();
    wr_en = 1'b0;
    chk("fullrw_count", cnt0, 15);
    chk("fullrw_ovf", ovf0, 1);
    chk("fullrw_data", r0_data, 8'h40);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("fullrw_drain", r0_data, 8'h41 + i);
    end
    rd_en = 1'b0;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("fullrw_empty", cnt0, 0);
    chk("fullrw_clr", ovf0, 0);

    // Simultaneous read/write at count=5
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'(8'h50 + i);
      tick();
    end
    wr_data = 8'h55;
    rd_en = 1'b1;
    tick();
    wr_en = 1'b0;
    chk("mid_count", cnt0, 5);
    chk("mid_data", r0_data, 8'h50);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mid_drain", r0_data, 8'h51 + i);
    end
    rd_en = 1'b0;
    tick();
    chk("mid_empty", empty0, 1);

    // Simultaneous read/write while empty: write only, read flagged
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h60;
    tick();
    wr_en = 1'b0;
    chk("emptyrw_count", cnt0, 1);
    chk("emptyrw_unf", unf0, 1);
    chk("emptyrw_valid", r0_valid, 0);
    tick();
    rd_en = 1'b0;
    chk("emptyrw_data", r0_data, 8'h60);
    chk("emptyrw_cnt0", cnt0, 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;

    // Streaming across pointer wrap, data 0x10..0x37, occupancy held at 5
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'(8'h10 + i);
      tick();
    end
    rd_en = 1'b1;
    for (int k = 0; k < 35; k++) begin
      wr_data = 8'(8'h15 + k);
      tick();
      chk("wrap_data", r0_data, 8'h10 + k);
      chk("wrap_count", cnt0, 5);
    end
    wr_en = 1'b0;
    for (int k = 35; k < 40; k++) begin
      tick();
      chk("wrap_tail", r0_data, 8'h10 + k);
    end
    rd_en = 1'b0;
    tick();
    chk("wrap_empty", empty0, 1);
    chk("wrap_ovf", ovf0, 0);
    chk("wrap_unf", unf0, 0);

    // FWFT versus standard read latency
    wr_en = 1'b1; wr_data = 8'h5A;
    tick();
    wr_en = 1'b0;
    chk("fwft_data", r1_data, 8'h5A);
    chk("fwft_valid", r1_valid, 1);
    chk("std_valid_idle", r0_valid, 0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("fwft_empty", empty1, 1);
    chk("fwft_valid_off", r1_valid, 0);
    chk("std_valid", r0_valid, 1);
    chk("std_data", r0_data, 8'h5A);
    tick();
    chk("std_valid_off", r0_valid, 0);

    // Asynchronous reset at count=9
    wr_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wr_data = 8'(8'h70 + i);
      tick();
    end
    wr_en = 1'b0;
    chk("pre_arst_count", cnt0, 9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", cnt0, 0);
    chk("arst_empty", empty0, 1);
    chk("arst_full", full0, 0);
    chk("arst_afull", af0, 0);
    chk("arst_ovf", ovf0, 0);
    chk("arst_unf", unf0, 0);
    chk("arst_fwft_valid", r1_valid, 0);
    chk("arst_fwft_count", cnt1, 0);
    tick();
    rst_n = 1'b1;
    tick();
    wr_en = 1'b1; wr_data = 8'h33;
    tick();
    wr_en = 1'b0;
    chk("post_fwft_data", r1_data, 8'h33);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("post_valid", r0_valid, 1);
    chk("post_data", r0_data, 8'h33);
    chk("post_empty", empty0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
